// File: rtl/dram4116_ctrl.sv
// dram4116_ctrl: request/done front end for an MK4116 16K x 1 DRAM.
// Splits a flat 14-bit address into row/column phases and drives registered
// nRAS/nCAS/nWRITE/A/Din strobes; reads sample Dout during precharge.
// Optional feature macro: DRAM4116_REFRESH_EN adds a periodic RAS-only refresh
// engine (timer, row counter, RFR_* states). Without it nRAS falls only for accesses.
module dram4116_ctrl #(
  parameter int T_CAS            = 2,
  parameter int T_RP             = 2,
  parameter int T_RFR            = 3,
  parameter int REFRESH_INTERVAL = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic [13:0] addr,
  input  logic        wdata,
  output logic        ready,
  output logic        done,
  output logic        rdata,
  output logic [6:0]  A,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nWRITE,
  output logic        Din,
  input  logic        Dout
);

  typedef enum logic [2:0] {IDLE, ROW, RAS, COL, CAS, PRE, RFR_ROW, RFR_RAS} state_t;

  localparam int CW = 8;

  if (T_CAS < 1 || T_RP < 2 || T_RFR < 1 || REFRESH_INTERVAL < 8) begin : g_bad_params
    $error("dram4116_ctrl: timing parameter below its minimum");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    a_q, a_d;
  logic [6:0]    col_q, col_d;
  logic          nRas_q, nRas_d;
  logic          nCas_q, nCas_d;
  logic          nWrite_q, nWrite_d;
  logic          din_q, din_d;
  logic          done_q, done_d;
  logic          rdata_q, rdata_d;
  logic          isRead_q, isRead_d;
  logic          inRfr_q, inRfr_d;
  logic          rfrDue;

`ifdef DRAM4116_REFRESH_EN
  localparam int TW = $clog2(REFRESH_INTERVAL);

  logic [TW-1:0] timer_q;
  logic          pending_q, pending_d;
  logic [6:0]    rfrRow_q, rfrRow_d;
  logic          wrap;

  // A wrap in the same cycle as an idle controller starts the refresh directly,
  // so a simultaneous request can never slip in ahead of it.
  assign wrap   = (timer_q == TW'(REFRESH_INTERVAL - 1));
  assign rfrDue = pending_q || wrap;

  // Free-running refresh timer, pending flag and refresh row counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      rfrRow_q  <= '0;
    end else begin
      timer_q   <= wrap ? '0 : timer_q + 1'b1;
      pending_q <= pending_d;
      rfrRow_q  <= rfrRow_d;
    end
  end
`else
  assign rfrDue = 1'b0;
`endif

  assign ready  = (state_q == IDLE) && !rfrDue;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign A      = a_q;
  assign nRAS   = nRas_q;
  assign nCAS   = nCas_q;
  assign nWRITE = nWrite_q;
  assign Din    = din_q;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    col_d    = col_q;
    nRas_d   = nRas_q;
    nCas_d   = nCas_q;
    nWrite_d = nWrite_q;
    din_d    = din_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    isRead_d = isRead_q;
    inRfr_d  = inRfr_q;
`ifdef DRAM4116_REFRESH_EN
    pending_d = pending_q | wrap;
    rfrRow_d  = rfrRow_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DRAM4116_REFRESH_EN
        if (rfrDue) begin
          state_d   = RFR_ROW;
          a_d       = rfrRow_q;
          inRfr_d   = 1'b1;
          pending_d = 1'b0;
        end else
`endif
        if (req) begin
          state_d  = ROW;
          a_d      = addr[13:7];
          col_d    = addr[6:0];
          nWrite_d = ~we;
          din_d    = wdata;
          isRead_d = ~we;
          inRfr_d  = 1'b0;
        end
      end
      ROW: begin
        state_d = RAS;
        nRas_d  = 1'b0;
      end
      RAS: begin
        state_d = COL;
        a_d     = col_q;
      end
      COL: begin
        state_d = CAS;
        nCas_d  = 1'b0;
        cnt_d   = '0;
      end
      CAS: begin
        if (cnt_q == CW'(T_CAS - 1)) begin
          state_d  = PRE;
          nRas_d   = 1'b1;
          nCas_d   = 1'b1;
          nWrite_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == '0 && !inRfr_q) begin
          done_d = 1'b1;
          if (isRead_q) begin
            rdata_d = Dout;
          end
        end
        if (cnt_q == CW'(T_RP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DRAM4116_REFRESH_EN
      RFR_ROW: begin
        state_d = RFR_RAS;
        nRas_d  = 1'b0;
        cnt_d   = '0;
      end
      RFR_RAS: begin
        if (cnt_q == CW'(T_RFR - 1)) begin
          state_d  = PRE;
          nRas_d   = 1'b1;
          cnt_d    = '0;
          rfrRow_d = rfrRow_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered DRAM-side outputs; reset drops any access in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      col_q    <= '0;
      nRas_q   <= 1'b1;
      nCas_q   <= 1'b1;
      nWrite_q <= 1'b1;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 1'b0;
      isRead_q <= 1'b0;
      inRfr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      col_q    <= col_d;
      nRas_q   <= nRas_d;
      nCas_q   <= nCas_d;
      nWrite_q <= nWrite_d;
      din_q    <= din_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      isRead_q <= isRead_d;
      inRfr_q  <= inRfr_d;
    end
  end

endmodule

// File: tb/tb_dram4116_ctrl.sv
// tb_dram4116_ctrl: directed bench for dram4116_ctrl with a behavioural MK4116.
// Inputs change and outputs are sampled on the falling clock edge.
// Refresh-specific scenarios are compiled only when DRAM4116_REFRESH_EN is defined.
module tb_dram4116_ctrl;

`ifdef DRAM4116_REFRESH_EN
  localparam int NB2B = 2;
`else
  localparam int NB2B = 3;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [13:0] addr = '0;
  logic        wdata = 1'b0;
  logic        ready, done, rdata;
  logic [6:0]  A;
  logic        nRAS, nCAS, nWRITE, Din;
  logic        Dout;

  int total = 0;
  int bad   = 0;

  dram4116_ctrl dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .A(A), .nRAS(nRAS), .nCAS(nCAS),
    .nWRITE(nWRITE), .Din(Din), .Dout(Dout)
  );

  always #5 CLK = ~CLK;

  // Behavioural 16K x 1 DRAM: row latched on nRAS fall, column on nCAS fall.
  bit         mem [0:16383];
  logic [6:0] rowLat = '0;
  bit         doutR = 1'b0;
  assign Dout = doutR;

  always @(negedge nRAS) rowLat = A;

  always @(negedge nCAS) begin
    if (!nWRITE) mem[{rowLat, A}] = Din;
    else doutR = mem[{rowLat, A}];
  end

  task automatic applyReset();
    RESET = 1'b1;
    req   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic waitReady(output bit ok);
    ok = ready;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      ok = ready;
    end
  endtask

  // Issues one access from a ready IDLE cycle and records what the DRAM side saw.
  task automatic applyStimulus(input logic w, input logic [13:0] a, input logic d,
                               output int doneAt, output logic rd,
                               output logic [6:0] rasA, output logic [6:0] casA,
                               output logic casNw, output int rasFalls,
                               output int casFalls, output logic readyNext);
    logic pRas, pCas;
    logic [6:0] pA;
    doneAt = 0; rd = 1'b0; rasA = '0; casA = '0; casNw = 1'b1;
    rasFalls = 0; casFalls = 0; readyNext = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d;
    pRas = nRAS; pCas = nCAS; pA = A;
    for (int n = 1; n <= 9; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      end
      if (pRas && !nRAS) begin rasFalls++; rasA = pA; end
      if (pCas && !nCAS) begin casFalls++; casA = pA; casNw = nWRITE; end
      if (done && doneAt == 0) begin doneAt = n; rd = rdata; end
      if (doneAt != 0 && n == doneAt + 1) readyNext = ready;
      pRas = nRAS; pCas = nCAS; pA = A;
    end
  endtask

  task automatic test_reset();
    applyReset();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (nRAS !== 1'b1) begin bad++; $display("FAIL reset_nRAS: got %b want 1", nRAS); end
    total++; if (nCAS !== 1'b1) begin bad++; $display("FAIL reset_nCAS: got %b want 1", nCAS); end
    total++; if (nWRITE !== 1'b1) begin bad++; $display("FAIL reset_nWRITE: got %b want 1", nWRITE); end
    total++; if (A !== 7'h00) begin bad++; $display("FAIL reset_A: got %h want 00", A); end
    total++; if (Din !== 1'b0) begin bad++; $display("FAIL reset_Din: got %b want 0", Din); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rdata !== 1'b0) begin bad++; $display("FAIL reset_rdata: got %b want 0", rdata); end
  endtask

  // Write 1 to 0x1234: row 0x24, column 0x34, early write, done 7 cycles after acceptance.
  task automatic test_write();
    int dAt, rf, cf;
    logic rd, nw, rn;
    logic [6:0] ra, ca;
    applyReset();
    applyStimulus(1'b1, 14'h1234, 1'b1, dAt, rd, ra, ca, nw, rf, cf, rn);
    total++; if (ra !== 7'h24) begin bad++; $display("FAIL write_row_addr: got %h want 24", ra); end
    total++; if (ca !== 7'h34) begin bad++; $display("FAIL write_col_addr: got %h want 34", ca); end
    total++; if (nw !== 1'b0) begin bad++; $display("FAIL write_nWRITE_at_cas: got %b want 0", nw); end
    total++; if (dAt !== 7) begin bad++; $display("FAIL write_done_cycle: got %0d want 7", dAt); end
    total++; if (rf !== 1 || cf !== 1) begin bad++; $display("FAIL write_strobe_count: got ras=%0d cas=%0d want 1/1", rf, cf); end
    total++; if (rn !== 1'b1) begin bad++; $display("FAIL write_ready_after: got %b want 1", rn); end
  endtask

  // Read back 1, overwrite with 0, read back 0.
  task automatic test_read();
    int dAt, rf, cf;
    logic rd, nw, rn;
    logic [6:0] ra, ca;
    applyReset();
    applyStimulus(1'b0, 14'h1234, 1'b0, dAt, rd, ra, ca, nw, rf, cf, rn);
    total++; if (dAt !== 7) begin bad++; $display("FAIL read1_done_cycle: got %0d want 7", dAt); end
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL read1_rdata: got %b want 1", rd); end
    total++; if (nw !== 1'b1) begin bad++; $display("FAIL read1_nWRITE_at_cas: got %b want 1", nw); end
    applyReset();
    applyStimulus(1'b1, 14'h1234, 1'b0, dAt, rd, ra, ca, nw, rf, cf, rn);
    applyReset();
    applyStimulus(1'b0, 14'h1234, 1'b1, dAt, rd, ra, ca, nw, rf, cf, rn);
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL read0_rdata: got %b want 0", rd); end
  endtask

  // Request held high: accepts 8 cycles apart, one nRAS and one nCAS pulse each.
  task automatic test_back_to_back();
    int rf, cf, dc;
    int dAt [0:2];
    logic pRas, pCas;
    rf = 0; cf = 0; dc = 0;
    for (int i = 0; i < 3; i++) dAt[i] = 0;
    applyReset();
    req = 1'b1; we = 1'b1; addr = 14'h0AAA; wdata = 1'b1;
    pRas = nRAS; pCas = nCAS;
    for (int n = 1; n <= 8 * NB2B; n++) begin
      @(negedge CLK);
      if (pRas && !nRAS) rf++;
      if (pCas && !nCAS) cf++;
      if (done) begin
        if (dc < 3) dAt[dc] = n;
        dc++;
      end
      pRas = nRAS; pCas = nCAS;
    end
    req = 1'b0;
    total++; if (rf !== NB2B) begin bad++; $display("FAIL b2b_ras_pulses: got %0d want %0d", rf, NB2B); end
    total++; if (cf !== NB2B) begin bad++; $display("FAIL b2b_cas_pulses: got %0d want %0d", cf, NB2B); end
    total++; if (dc !== NB2B) begin bad++; $display("FAIL b2b_done_count: got %0d want %0d", dc, NB2B); end
    for (int i = 0; i < NB2B; i++) begin
      total++;
      if (dAt[i] !== 7 + 8 * i) begin bad++; $display("FAIL b2b_done_cycle[%0d]: got %0d want %0d", i, dAt[i], 7 + 8 * i); end
    end
  endtask

`ifdef DRAM4116_REFRESH_EN
  // Idle bus for 16*130 cycles: 130 RAS-only pulses, 3 cycles each, rows 0..127,0,1.
  task automatic test_refresh();
    int cnt, seqErr, lenErr, casErr, len;
    logic pRas;
    logic [6:0] pA, expRow;
    cnt = 0; seqErr = 0; lenErr = 0; casErr = 0; len = 0;
    applyReset();
    pRas = nRAS; pA = A;
    for (int n = 1; n <= 16 * 130 + 8; n++) begin
      @(negedge CLK);
      if (pRas && !nRAS) begin
        expRow = 7'(cnt % 128);
        if (pA !== expRow) seqErr++;
        cnt++;
        len = 0;
      end
      if (!nRAS) begin
        len++;
        if (nCAS !== 1'b1) casErr++;
      end
      if (!pRas && nRAS && len != 3) lenErr++;
      pRas = nRAS; pA = A;
    end
    total++; if (cnt !== 130) begin bad++; $display("FAIL rfr_pulse_count: got %0d want 130", cnt); end
    total++; if (seqErr !== 0) begin bad++; $display("FAIL rfr_row_sequence: got %0d wrong rows want 0", seqErr); end
    total++; if (lenErr !== 0) begin bad++; $display("FAIL rfr_pulse_len: got %0d bad pulses want 0", lenErr); end
    total++; if (casErr !== 0) begin bad++; $display("FAIL rfr_cas_high: got %0d low samples want 0", casErr); end
  endtask

  // Request raised as the timer wraps: refresh of row 0 runs first, access done 13 cycles later.
  task automatic test_refresh_priority();
    int dAt, rf, cf, doneN;
    logic rd, nw, rn, sawReady, rdv;
    logic [6:0] ra, ca;
    applyReset();
    applyStimulus(1'b1, 14'h0155, 1'b1, dAt, rd, ra, ca, nw, rf, cf, rn);
    repeat (7) @(negedge CLK);
    req = 1'b1; we = 1'b0; addr = 14'h0155; wdata = 1'b0;
    sawReady = 1'b0; doneN = 0; rdv = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        total++;
        if (nRAS !== 1'b0 || nCAS !== 1'b1 || A !== 7'h00) begin
          bad++; $display("FAIL prio_refresh_first: got nRAS=%b nCAS=%b A=%h want 0/1/00", nRAS, nCAS, A);
        end
      end
      if (sawReady) req = 1'b0;
      if (ready) sawReady = 1'b1;
      if (done && doneN == 0) begin doneN = n; rdv = rdata; end
    end
    req = 1'b0;
    total++; if (doneN !== 13) begin bad++; $display("FAIL prio_done_cycle: got %0d want 13", doneN); end
    total++; if (rdv !== 1'b1) begin bad++; $display("FAIL prio_rdata: got %b want 1", rdv); end
  endtask
`endif

  // Reset during CAS of a write drops it; refresh row restarts from 0.
  task automatic test_reset_mid();
    int dAt, rf, cf, doneCnt, fallN;
    logic rd, nw, rn, pRas;
    logic [6:0] ra, ca, pA, fallA;
    bit ok;
    waitReady(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_wait_ready1: got timeout want ready"); end
    applyStimulus(1'b0, 14'h0AAA, 1'b0, dAt, rd, ra, ca, nw, rf, cf, rn);
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL mid_pre_read: got %b want 1", rd); end
    waitReady(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_wait_ready2: got timeout want ready"); end
    req = 1'b1; we = 1'b1; addr = 14'h0077; wdata = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (nCAS !== 1'b0 || nWRITE !== 1'b0) begin bad++; $display("FAIL mid_in_cas: got nCAS=%b nWRITE=%b want 0/0", nCAS, nWRITE); end
    RESET = 1'b1;
    @(negedge CLK);
    total++;
    if (nRAS !== 1'b1 || nCAS !== 1'b1 || nWRITE !== 1'b1 || done !== 1'b0 || rdata !== 1'b0) begin
      bad++; $display("FAIL mid_forced_reset: got nRAS=%b nCAS=%b nWRITE=%b done=%b rdata=%b want 1/1/1/0/0",
                      nRAS, nCAS, nWRITE, done, rdata);
    end
    @(negedge CLK);
    RESET = 1'b0;
    total++; if (ready !== 1'b1 || A !== 7'h00) begin bad++; $display("FAIL mid_after_release: got ready=%b A=%h want 1/00", ready, A); end
    doneCnt = 0; fallN = 0; fallA = '0;
    pRas = nRAS; pA = A;
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      if (done) doneCnt++;
      if (pRas && !nRAS && fallN == 0) begin fallN = n; fallA = pA; end
      pRas = nRAS; pA = A;
    end
    total++; if (doneCnt !== 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", doneCnt); end
`ifdef DRAM4116_REFRESH_EN
    total++; if (fallN !== 17) begin bad++; $display("FAIL mid_first_refresh_cycle: got %0d want 17", fallN); end
    total++; if (fallA !== 7'h00) begin bad++; $display("FAIL mid_refresh_row: got %h want 00", fallA); end
`else
    total++; if (fallN !== 0) begin bad++; $display("FAIL mid_no_refresh: got nRAS fall at %0d want none", fallN); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
`ifdef DRAM4116_REFRESH_EN
    test_refresh();
    test_refresh_priority();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dram4116_ctrl.md
Name: dram4116_ctrl

Overview:
- Synchronous DRAM controller that sits directly upstream of the MK4116 16K x 1 DRAM model.
- Turns a simple request/done handshake with a flat 14-bit address into multiplexed row/column addresses and nRAS/nCAS/nWRITE/Din strobes; samples Dout for reads.
- Issues periodic RAS-only refresh cycles from an internal row counter.
- Used by the memory side of the ULA testbench to drive one or more 4116 bit-planes.

Parameters:
- T_CAS, 2, cycles nCAS held low (min 1).
- T_RP, 2, precharge cycles with nRAS/nCAS high (min 2).
- T_RFR, 3, cycles nRAS held low during a refresh (min 1).
- REFRESH_INTERVAL, 16, CLK cycles between refresh requests (min 8).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1=write, 0=read; sampled with req.
- addr  in  14  word address; row=addr[13:7], column=addr[6:0].
- wdata  in  1  write data; sampled with req.
- ready  out  1  1 when in IDLE and no refresh pending.
- done  out  1  one-cycle pulse when an access completes.
- rdata  out  1  read data; valid while done=1 for a read, holds value otherwise.
- A  out  7  multiplexed DRAM address.
- nRAS  out  1  row strobe, active low.
- nCAS  out  1  column strobe, active low.
- nWRITE  out  1  write enable, active low.
- Din  out  1  data to DRAM.
- Dout  in  1  data from DRAM.

Behaviour:
- Reset: state=IDLE, nRAS=1, nCAS=1, nWRITE=1, A=0, Din=0, done=0, rdata=0, refresh row=0, refresh timer=0, pending=0. ready=1 in the first cycle after RESET deasserts.
- All DRAM outputs are registered. A is stable at least one full cycle before each nRAS/nCAS falling edge.
- Access accepted at edge k (IDLE, ready=1, req=1):
  - Cycle k+1, ROW: A=row; nWRITE=~we; Din=wdata.
  - k+2, RAS: nRAS=0.
  - k+3, COL: A=col.
  - k+4 .. k+3+T_CAS, CAS: nCAS=0.
  - PRE: nRAS=1, nCAS=1, nWRITE=1 for T_RP cycles.
  - Reads: Dout is sampled at the end of the first PRE cycle.
  - done=1 in the second PRE cycle (rdata valid if read), then IDLE.
  - Default timing: done at k+7, ready again at k+8.
- Write is early-write only: nWRITE is low and Din is valid before nCAS falls, and both are held through CAS.
- req while ready=0 is ignored; the requester must hold req until it sees ready=1.
- Refresh timer:
  - Free-running modulo REFRESH_INTERVAL.
  - At wrap it sets pending.
  - A wrap while pending is already set is lost (not queued).
- IDLE with pending=1: refresh has priority over req, even when both occur in the same cycle; ready=0.
  - RFR_ROW (1 cycle): A=refresh row; pending is cleared.
  - RFR_RAS: nRAS=0 for T_RFR cycles; nCAS and nWRITE stay 1.
  - PRE for T_RP cycles, then IDLE. No done pulse.
  - Refresh row increments mod 128 on leaving RFR_RAS; 127 wraps to 0.
- RESET mid-operation: next edge forces the reset values. The in-flight access is dropped with no done, and any pending refresh is cleared.

Optional Feature:
- Macro DRAM4116_REFRESH_EN.
- Defined: refresh timer, row counter and RFR_* states are present as above.
- Undefined: no refresh logic; ready = (state==IDLE); nRAS falls only for accesses.

Test Plan:
- Write 1 to addr 0x1234 with a connected MK4116 model:
  - A=0x24 at the nRAS fall, A=0x34 at the nCAS fall, nWRITE=0 at the nCAS fall.
  - done at k+7.
- Read addr 0x1234 after that write -> done at k+7 with rdata=1. Then write 0 and read again -> rdata=0.
- Back-to-back requests with req held high -> accepts 8 cycles apart; each access has exactly one nRAS and one nCAS pulse.
- REFRESH_EN, bus idle for 16*130 cycles:
  - 130 RAS-only pulses, each 3 cycles long with nCAS=1.
  - Refresh A sequence 0,1,...,127,0,1.
- req asserted in the same cycle the refresh timer wraps -> refresh cycle first, then the access. Access done at 13 cycles after req, with correct data.
- RESET asserted during CAS of a write -> next cycle nRAS=nCAS=nWRITE=1, no done. ready=1 in the first cycle after RESET drops, and the refresh row restarts at 0.
